// File: rtl/lc3b_mem_arbiter.sv
// LC-3b memory arbiter: one-line fetch buffer plus a data port,
// multiplexed onto a single Wishbone-style line bus.
module lc3b_mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int LINE_W = 128,
    parameter int SEL_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifetch_read,
    input  logic [ADDR_W-1:0] ifetch_address,
    output logic [LINE_W-1:0] ifetch_rdata,
    output logic              ifetch_resp,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [LINE_W-1:0] mem_wdata,
    input  logic [SEL_W-1:0]  mem_sel,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_resp,
    output logic              pm_cyc,
    output logic              pm_stb,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_adr,
    output logic [LINE_W-1:0] pm_dat_o,
    output logic [SEL_W-1:0]  pm_sel,
    input  logic [LINE_W-1:0] pm_dat_i,
    input  logic              pm_ack
);

    typedef enum logic [1:0] {IDLE, DATA, FETCH, DONE} state_t;

    state_t state, state_nx;

    logic              buf_valid;
    logic [ADDR_W-1:0] buf_tag;
    logic [LINE_W-1:0] buf_data;
    logic [ADDR_W-1:0] lat_adr;
    logic [LINE_W-1:0] lat_wdata;
    logic [SEL_W-1:0]  lat_sel;
    logic              lat_we;
    logic              hit;
    logic              data_req;
    logic              busy;

    assign hit          = buf_valid && (buf_tag == ifetch_address);
    assign data_req     = mem_read | mem_write;
    assign ifetch_resp  = ifetch_read & hit;
    assign ifetch_rdata = buf_data;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (data_req)
                    state_nx = DATA;
                else if (ifetch_read && !hit)
                    state_nx = FETCH;
            end
            DATA:    if (pm_ack) state_nx = DONE;
            FETCH:   if (pm_ack) state_nx = IDLE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
            mem_rdata <= '0;
            lat_adr   <= '0;
            lat_wdata <= '0;
            lat_sel   <= '0;
            lat_we    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                if (data_req) begin
                    lat_adr   <= mem_address;
                    lat_wdata <= mem_wdata;
                    lat_we    <= mem_write;
                    lat_sel   <= mem_write ? mem_sel : '1;
                end else if (ifetch_read && !hit) begin
                    lat_adr <= ifetch_address;
                    lat_we  <= 1'b0;
                    lat_sel <= '1;
                end
            end
            if (state == DATA && pm_ack) begin
                if (!lat_we)
                    mem_rdata <= pm_dat_i;
                else if (lat_adr == buf_tag)
                    buf_valid <= 1'b0;
            end
            // A refill always installs the address it was issued for.
            if (state == FETCH && pm_ack) begin
                buf_data  <= pm_dat_i;
                buf_tag   <= lat_adr;
                buf_valid <= 1'b1;
            end
        end
    end

    assign busy     = (state == DATA) || (state == FETCH);
    assign mem_resp = (state == DONE);
    assign pm_cyc   = busy;
    assign pm_stb   = busy;
    assign pm_we    = busy & lat_we;
    assign pm_adr   = busy ? lat_adr : '0;
    assign pm_dat_o = busy ? lat_wdata : '0;
    assign pm_sel   = busy ? lat_sel : '0;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Directed bench for lc3b_mem_arbiter with a
// wait-state-programmable bus responder.
module tb_lc3b_mem_arbiter;

    logic         clk = 0;
    logic         rst_n = 0;
    logic         ifetch_read = 0;
    logic [11:0]  ifetch_address = 0;
    logic [127:0] ifetch_rdata;
    logic         ifetch_resp;
    logic         mem_read = 0;
    logic         mem_write = 0;
    logic [11:0]  mem_address = 0;
    logic [127:0] mem_wdata = 0;
    logic [15:0]  mem_sel = 0;
    logic [127:0] mem_rdata;
    logic         mem_resp;
    logic         pm_cyc, pm_stb, pm_we;
    logic [11:0]  pm_adr;
    logic [127:0] pm_dat_o;
    logic [15:0]  pm_sel;
    logic [127:0] pm_dat_i = 0;
    logic         pm_ack = 0;

    int checks = 0;
    int failures = 0;
    int waits = 0;
    int wcnt = 0;
    int n_stb, n_resp;

    lc3b_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ifetch_read(ifetch_read), .ifetch_address(ifetch_address),
        .ifetch_rdata(ifetch_rdata), .ifetch_resp(ifetch_resp),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pm_cyc(pm_cyc), .pm_stb(pm_stb), .pm_we(pm_we),
        .pm_adr(pm_adr), .pm_dat_o(pm_dat_o), .pm_sel(pm_sel),
        .pm_dat_i(pm_dat_i), .pm_ack(pm_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] line(input logic [11:0] a);
        return {8{4'hA, a}};
    endfunction

    // Bus slave: acks after `waits` stalled cycles.
    initial forever begin
        @(negedge clk);
        if (pm_stb) begin
            if (wcnt >= waits) begin
                pm_ack   = 1;
                pm_dat_i = line(pm_adr);
            end else begin
                pm_ack = 0;
                wcnt++;
            end
        end else begin
            pm_ack = 0;
            wcnt   = 0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        cyc(); cyc();
        rst_n = 1;
        cyc();
        chk("rst_stb", pm_stb, 0);
        chk("rst_cyc", pm_cyc, 0);
        chk("rst_resp", mem_resp, 0);
        chk("rst_ifr", ifetch_resp, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_adr", pm_adr, 0);
        chk("rst_sel", pm_sel, 0);

        // fetch miss at 0x010
        ifetch_read = 1; ifetch_address = 12'h010;
        #1 chk("f_miss", ifetch_resp, 0);
        cyc();
        chk("f_stb", pm_stb, 1);
        chk("f_adr", pm_adr, 12'h010);
        chk("f_we", pm_we, 0);
        chk("f_sel", pm_sel, 16'hFFFF);
        cyc();
        chk("f_resp", ifetch_resp, 1);
        chk("f_line", ifetch_rdata, line(12'h010));
        chk("f_idle", pm_stb, 0);
        cyc();
        chk("f_hold", ifetch_resp, 1);

        // write hitting the buffered line
        mem_write = 1; mem_address = 12'h010;
        mem_wdata = {4{32'hDEADBEEF}}; mem_sel = 16'h0003;
        cyc();
        chk("w_stb", pm_stb, 1);
        chk("w_we", pm_we, 1);
        chk("w_sel", pm_sel, 16'h0003);
        chk("w_dat", pm_dat_o, {4{32'hDEADBEEF}});
        chk("w_ifr", ifetch_resp, 1);
        cyc();
        chk("w_resp", mem_resp, 1);
        chk("w_inv", ifetch_resp, 0);
        chk("w_rdata", mem_rdata, 0);
        mem_write = 0;
        cyc();
        chk("w_resp1", mem_resp, 0);
        cyc();
        chk("w_ref_stb", pm_stb, 1);
        chk("w_ref_adr", pm_adr, 12'h010);
        cyc();
        chk("w_ref_ifr", ifetch_resp, 1);

        // simultaneous data read and fetch miss
        ifetch_address = 12'h200;
        mem_read = 1; mem_address = 12'h123;
        cyc();
        chk("s_adr", pm_adr, 12'h123);
        chk("s_we", pm_we, 0);
        cyc();
        chk("s_resp", mem_resp, 1);
        chk("s_rdata", mem_rdata, line(12'h123));
        mem_read = 0;
        cyc();
        chk("s_resp1", mem_resp, 0);
        chk("s_ifr0", ifetch_resp, 0);
        cyc();
        chk("s_f_stb", pm_stb, 1);
        chk("s_f_adr", pm_adr, 12'h200);
        cyc();
        chk("s_f_ifr", ifetch_resp, 1);
        chk("s_f_line", ifetch_rdata, line(12'h200));

        // 3 wait states
        waits = 3;
        mem_read = 1; mem_address = 12'h055;
        n_stb = 0; n_resp = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (pm_stb) n_stb++;
            if (mem_resp) begin
                n_resp++;
                mem_read = 0;
            end
        end
        chk("ws_stb", n_stb, 4);
        chk("ws_resp", n_resp, 1);
        chk("ws_rdata", mem_rdata, line(12'h055));
        waits = 0;

        // LDI: back-to-back reads
        mem_read = 1; mem_address = 12'h040;
        cyc();
        chk("l1_adr", pm_adr, 12'h040);
        cyc();
        chk("l1_resp", mem_resp, 1);
        chk("l1_rdata", mem_rdata, line(12'h040));
        mem_address = 12'h0A0;
        cyc();
        chk("l_gap_stb", pm_stb, 0);
        chk("l_gap_resp", mem_resp, 0);
        cyc();
        chk("l2_stb", pm_stb, 1);
        chk("l2_adr", pm_adr, 12'h0A0);
        cyc();
        chk("l2_resp", mem_resp, 1);
        chk("l2_rdata", mem_rdata, line(12'h0A0));
        mem_read = 0;
        cyc();

        // reset mid-DATA with a stalled bus
        waits = 1000;
        mem_read = 1; mem_address = 12'h077;
        cyc();
        chk("r_stb", pm_stb, 1);
        #2 rst_n = 0;
        #1;
        chk("r_stb0", pm_stb, 0);
        chk("r_ifr0", ifetch_resp, 0);
        chk("r_rdata0", mem_rdata, 0);
        mem_read = 0; ifetch_read = 0; waits = 0;
        cyc(); cyc();
        rst_n = 1;
        n_resp = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (mem_resp) n_resp++;
        end
        chk("r_noresp", n_resp, 0);
        chk("r_idle", pm_stb, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3b_mem_arbiter.md
# lc3b_mem_arbiter

Two-port to one-port memory arbiter between the pipelined LC-3b datapath and the shared physical memory bus. It serves the instruction-fetch port from a one-line fetch buffer, refilling it on a miss. It serves data-port reads and writes, including the second access of LDI/STI issued by the stall unit, as single Wishbone-style line transactions. Data requests have fixed priority over fetch-buffer refills.

## Interface
Parameters:
- ADDR_W, 12, line address width (16-bit byte address [15:4])
- LINE_W, 128, line width in bits
- SEL_W, 16, byte-select width (LINE_W/8)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ifetch_read  in  1  fetch request, level
- ifetch_address  in  ADDR_W  fetch line address
- ifetch_rdata  out  LINE_W  fetch buffer contents
- ifetch_resp  out  1  fetch buffer holds requested line
- mem_read  in  1  data read request, level until mem_resp
- mem_write  in  1  data write request, level until mem_resp
- mem_address  in  ADDR_W  data line address
- mem_wdata  in  LINE_W  write line data
- mem_sel  in  SEL_W  write byte enables
- mem_rdata  out  LINE_W  registered read line
- mem_resp  out  1  one-cycle completion pulse
- pm_cyc, pm_stb  out  1  bus cycle / strobe (always equal)
- pm_we  out  1  bus write
- pm_adr  out  ADDR_W  bus line address
- pm_dat_o  out  LINE_W  bus write data
- pm_sel  out  SEL_W  bus byte select
- pm_dat_i  in  LINE_W  bus read data
- pm_ack  in  1  bus acknowledge, valid while pm_stb is high

## Operation
- State: buf_valid, buf_tag[ADDR_W], buf_data[LINE_W]. ifetch_rdata = buf_data always.
- ifetch_resp = ifetch_read & buf_valid & (buf_tag == ifetch_address). This is combinational and stays high for as long as the fetch hits.
- FSM states: IDLE, DATA, FETCH, DONE.
- In IDLE, priority order:
  - If mem_read|mem_write, latch address/wdata/sel/we (we = mem_write) and go to DATA.
  - Otherwise, on a fetch miss (ifetch_read & !hit), latch ifetch_address and go to FETCH.
  - Otherwise stay in IDLE.
- mem_read & mem_write both high: treated as a write.
- DATA: pm_cyc=pm_stb=1, pm_we=latched we, pm_adr/pm_dat_o from latches. pm_sel = latched sel on a write, all ones on a read.
  - On pm_ack, capture pm_dat_i into mem_rdata (reads only; writes leave mem_rdata unchanged) and go to DONE.
  - A write ack whose address equals buf_tag clears buf_valid.
- DONE: mem_resp=1 for exactly this cycle, no bus activity, then IDLE. Requester changes or drops its request at the edge ending DONE. A level still present in the following IDLE cycle is a new request.
- FETCH: pm_cyc=pm_stb=1, pm_we=0, pm_sel all ones, pm_adr = latched fetch address.
  - On pm_ack, load buf_data=pm_dat_i, buf_tag=latched address, buf_valid=1, then go to IDLE.
  - If ifetch_address changes during FETCH, the stale line is still loaded; the new address misses and refills later.
- Fetch hits are served in parallel with any data transaction.
- Each state is left only on pm_ack. There is no timeout; the bus must eventually ack.

## Timing
- Reset (asynchronous, immediate): state=IDLE, buf_valid=0, buf_tag=0, buf_data=0, mem_rdata=0. mem_resp, ifetch_resp, pm_cyc, pm_stb and pm_we are 0; pm_adr, pm_dat_o and pm_sel are 0. Reset during DATA/FETCH drops pm_stb in the same cycle with no response.
- Data latency, with the request seen in IDLE at cycle 0 and ack in the first DATA cycle:
  - pm_stb is high in cycle 1.
  - mem_resp is high in cycle 2 and mem_rdata is valid in cycle 2.
  - Each bus wait state adds one cycle.
- Fetch miss latency: miss in cycle 0, pm_stb in cycle 1, ack in cycle 1, ifetch_resp high in cycle 2.
- A data request arriving while in FETCH waits for the fetch ack, is taken in the next IDLE cycle, and sees pm_stb one cycle later.
- Back-to-back data requests (LDI second access) issue pm_stb earliest 2 cycles after mem_resp.
- pm_* outputs are registered/state-decoded with no combinational path from upstream inputs.

## Test plan
- Reset mid-DATA read (pm_stb high, no ack) -> pm_stb 0 immediately, mem_resp never pulses, buf_valid 0.
- ifetch_read=1, address 0x010, bus acks the first cycle with line L -> pm_adr 0x010 pm_we 0 in cycle 1; ifetch_resp=1, ifetch_rdata=L in cycle 2 and onward while address is held.
- Simultaneous mem_read @0x123 and fetch miss @0x200 -> data transaction first, mem_resp pulses one cycle with the data line, then a fetch at 0x200.
- Write to 0x010 with sel 0x0003 while buffer holds 0x010 -> pm_we 1, pm_sel 0x0003; ifetch_resp drops the cycle after ack and refill of 0x010 follows.
- mem_read with a 3-wait-state bus -> pm_stb high 4 cycles, mem_resp exactly one cycle, mem_rdata stable afterwards.
- LDI sequence: read 0x040, then read 0x0A0 issued right after mem_resp -> two separate transactions, second pm_stb 2 cycles after first mem_resp.
